// File: rtl/arbitro_destino_pkg.sv
// Shared definitions for the destination arbiter: word field layout, FSM encodings and field helpers.
package arbitro_destino_pkg;

    localparam int ARB_WORD_SIZE = 12;
    localparam int ARB_NUM_CH    = 4;

    localparam int CLASS_MSB = 11;
    localparam int CLASS_LSB = 10;
    localparam int DEST_MSB  = 9;
    localparam int DEST_LSB  = 8;

    localparam logic [1:0] ST_INIT    = 2'b00;
    localparam logic [1:0] ST_IDLE    = 2'b01;
    localparam logic [1:0] ST_ACTIVE  = 2'b10;
    localparam logic [1:0] ST_BLOCKED = 2'b11;

    typedef logic [ARB_WORD_SIZE-1:0] word_t;

    function automatic logic [1:0] dest_of(input word_t w);
        return w[DEST_MSB:DEST_LSB];
    endfunction

    function automatic logic [ARB_NUM_CH-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/arbitro_destino_sel_clase.sv
// Four-way class selector: first non-empty class found scanning upward from ptr (mod 4).
module arbitro_destino_sel_clase
    import arbitro_destino_pkg::*;
(
    input  logic [3:0] empty,
    input  logic [1:0] ptr,
    output logic [1:0] grant,
    output logic       valid
);

    logic [1:0] idx_s;

    // Scan downward so the candidate closest to ptr is the last one written and therefore wins.
    always_comb begin
        grant = 2'd0;
        valid = 1'b0;
        idx_s = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx_s = ptr + k[1:0];
            if (!empty[idx_s]) begin
                grant = idx_s;
                valid = 1'b1;
            end else begin
                grant = grant;
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/arbitro_destino.sv
// Destination arbiter: drains 4 class FIFOs into 4 destination FIFOs, one word per cycle.
// Define ROUND_ROBIN_EN for round-robin class selection; default build is strict priority (class 0 first).
module arbitro_destino
    import arbitro_destino_pkg::*;
#(
    parameter int WORD_SIZE = ARB_WORD_SIZE,
    parameter int NUM_CH    = ARB_NUM_CH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH*WORD_SIZE-1:0] data_in_arb,
    input  logic [NUM_CH-1:0]           fifos_empty,
    input  logic [NUM_CH-1:0]           fifos_almost_full,
    output logic [NUM_CH-1:0]           pop,
    output logic [NUM_CH-1:0]           push,
    output logic [WORD_SIZE-1:0]        data_out_arb,
    output logic [4:0]                  cuenta,
    output logic [1:0]                  estado
);

    logic [1:0]           estado_r;
    logic [1:0]           next_s;
    logic [NUM_CH-1:0]    push_r;
    logic [WORD_SIZE-1:0] data_r;
    logic [4:0]           cuenta_r;
    logic [1:0]           blk_r;
    logic [1:0]           ptr_s;
    logic [1:0]           grant_s;
    logic                 valid_s;
    logic [NUM_CH-1:0]    pop_s;
    logic [WORD_SIZE-1:0] heads_s [NUM_CH];
    logic [WORD_SIZE-1:0] sel_head_s;
    logic [1:0]           sel_dest_s;
    logic [1:0]           blk_dest_s;
    logic                 pop_any_s;

    // Unpack the show-ahead head word of each class FIFO.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            heads_s[i] = data_in_arb[i*WORD_SIZE +: WORD_SIZE];
        end
    end

    assign sel_head_s = heads_s[grant_s];
    assign sel_dest_s = dest_of(sel_head_s);
    assign blk_dest_s = dest_of(heads_s[blk_r]);
    assign pop_any_s  = |pop_s;

    arbitro_destino_sel_clase u_sel_clase (
        .empty (fifos_empty),
        .ptr   (ptr_s),
        .grant (grant_s),
        .valid (valid_s)
    );

`ifdef ROUND_ROBIN_EN
    logic [1:0] rr_ptr_r;

    // Round-robin pointer advances past the granted class only when a word is actually popped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_r <= 2'd0;
        end else if (pop_any_s) begin
            rr_ptr_r <= grant_s + 2'd1;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign ptr_s = rr_ptr_r;
`else
    assign ptr_s = 2'd0;
`endif

    // Next-state and pop decode; a blocked head stalls the whole switch to keep head-of-line order.
    always_comb begin
        next_s = estado_r;
        pop_s  = {NUM_CH{1'b0}};
        case (estado_r)
            ST_INIT: begin
                next_s = ST_IDLE;
            end
            ST_IDLE: begin
                if (fifos_empty != {NUM_CH{1'b1}}) begin
                    next_s = ST_ACTIVE;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (!valid_s) begin
                    next_s = ST_IDLE;
                end else if (fifos_almost_full[sel_dest_s]) begin
                    next_s = ST_BLOCKED;
                end else begin
                    pop_s  = onehot4(grant_s);
                    next_s = ST_ACTIVE;
                end
            end
            ST_BLOCKED: begin
                if (fifos_empty[blk_r] || !fifos_almost_full[blk_dest_s]) begin
                    next_s = ST_ACTIVE;
                end else begin
                    next_s = ST_BLOCKED;
                end
            end
            default: begin
                next_s = ST_INIT;
            end
        endcase
    end

    // State, registered push/data one cycle behind the pop, forwarded-word counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_r <= ST_INIT;
            push_r   <= {NUM_CH{1'b0}};
            data_r   <= {WORD_SIZE{1'b0}};
            cuenta_r <= 5'd0;
            blk_r    <= 2'd0;
        end else begin
            estado_r <= next_s;
            if (pop_any_s) begin
                push_r   <= onehot4(sel_dest_s);
                data_r   <= sel_head_s;
                cuenta_r <= cuenta_r + 5'd1;
            end else begin
                push_r   <= {NUM_CH{1'b0}};
                data_r   <= data_r;
                cuenta_r <= cuenta_r;
            end
            if (estado_r == ST_ACTIVE) begin
                blk_r <= grant_s;
            end else begin
                blk_r <= blk_r;
            end
        end
    end

    assign pop          = pop_s;
    assign push         = push_r;
    assign data_out_arb = data_r;
    assign cuenta       = cuenta_r;
    assign estado       = estado_r;

endmodule

// File: tb/tb_arbitro_destino.sv
// Self-checking bench for arbitro_destino: queue-based class FIFO model plus forwarding scoreboard.
module tb_arbitro_destino;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] data_in_arb;
    logic [3:0]  fifos_empty;
    logic [3:0]  fifos_almost_full;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [11:0] data_out_arb;
    logic [4:0]  cuenta;
    logic [1:0]  estado;

    int checks = 0;
    int errors = 0;

    logic [11:0] q [4][$];
    logic [3:0]  exp_push;
    logic [11:0] exp_data;
    logic [4:0]  exp_cnt;
    int          last_cls;

    arbitro_destino dut (
        .clk               (clk),
        .reset             (reset),
        .data_in_arb       (data_in_arb),
        .fifos_empty       (fifos_empty),
        .fifos_almost_full (fifos_almost_full),
        .pop               (pop),
        .push              (push),
        .data_out_arb      (data_out_arb),
        .cuenta            (cuenta),
        .estado            (estado)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            fifos_empty[i] = (q[i].size() == 0);
            data_in_arb[i*12 +: 12] = (q[i].size() != 0) ? q[i][0] : 12'h000;
        end
    endtask

    task automatic model_reset();
        exp_push = 4'b0000;
        exp_data = 12'h000;
        exp_cnt  = 5'd0;
        last_cls = 3;
    endtask

    // Expected next class: strict priority, or first non-empty after the last granted class.
    function automatic int pick(input logic [3:0] ne, input int last);
        int r = -1;
`ifdef ROUND_ROBIN_EN
        for (int k = 1; k <= 4; k++) begin
            if (ne[(last + k) % 4] && r < 0) r = (last + k) % 4;
        end
`else
        for (int c = 0; c < 4; c++) begin
            if (ne[c] && r < 0) r = c;
        end
`endif
        return r;
    endfunction

    // Advance one clock: the FIFO model honours the pop observed this cycle.
    task automatic tick(input logic [3:0] p);
        int c = -1;
        logic [11:0] w;
        for (int i = 0; i < 4; i++) if (p[i] && c < 0) c = i;
        if (c >= 0 && q[c].size() != 0) begin
            w        = q[c][0];
            exp_push = 4'b0001 << w[9:8];
            exp_data = w;
            exp_cnt  = exp_cnt + 5'd1;
            last_cls = c;
        end else begin
            exp_push = 4'b0000;
        end
        @(posedge clk);
        #1;
        if (c >= 0 && q[c].size() != 0) void'(q[c].pop_front());
        drive_inputs();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) q[i].delete();
        fifos_almost_full = 4'b0000;
        drive_inputs();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_traffic(input string name, input int budget, input bit rand_af,
                               output int pops, output int pushes);
        int c;
        bit done = 1'b0;
        logic [3:0] p;
        pops = 0;
        pushes = 0;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            @(negedge clk);
            p = pop;
            checks += 3;
            if (push !== exp_push) begin
                errors++;
                $display("FAIL %s push: got %b expected %b", name, push, exp_push);
            end
            if (data_out_arb !== exp_data) begin
                errors++;
                $display("FAIL %s data_out_arb: got %h expected %h", name, data_out_arb, exp_data);
            end
            if (cuenta !== exp_cnt) begin
                errors++;
                $display("FAIL %s cuenta: got %0d expected %0d", name, cuenta, exp_cnt);
            end
            if (push !== 4'b0000) pushes++;
            if (p !== 4'b0000) begin
                pops++;
                c = pick(~fifos_empty, last_cls);
                checks++;
                if (c < 0 || p !== (4'b0001 << c)) begin
                    errors++;
                    $display("FAIL %s pop_select: got %b expected class %0d", name, p, c);
                end else if (fifos_almost_full[q[c][0][9:8]] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s pop_to_full_dest: pop %b with almost_full %b", name, p, fifos_almost_full);
                end
            end
            if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && q[3].size() == 0 &&
                estado == 2'b01 && push == 4'b0000) begin
                done = 1'b1;
            end else begin
                tick(p);
                if (rand_af) fifos_almost_full = 4'($urandom);
            end
        end
        fifos_almost_full = 4'b0000;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s drain_timeout: not idle after %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        fifos_almost_full = 4'b0000;
        for (int i = 0; i < 4; i++) q[i].delete();
        q[0].push_back(12'h123);
        q[3].push_back(12'hC55);
        drive_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        checks += 5;
        if (push !== 4'b0000) begin errors++; $display("FAIL reset push: got %b expected 0000", push); end
        if (pop !== 4'b0000) begin errors++; $display("FAIL reset pop: got %b expected 0000", pop); end
        if (cuenta !== 5'd0) begin errors++; $display("FAIL reset cuenta: got %0d expected 0", cuenta); end
        if (estado !== 2'b00) begin errors++; $display("FAIL reset estado: got %b expected 00", estado); end
        if (data_out_arb !== 12'h000) begin errors++; $display("FAIL reset data: got %h expected 000", data_out_arb); end
        for (int i = 0; i < 4; i++) q[i].delete();
        drive_inputs();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (estado !== 2'b01) begin errors++; $display("FAIL reset init_to_idle: got %b expected 01", estado); end
    endtask

    task automatic test_single();
        q[0].push_back(12'h2A5);
        drive_inputs();
        @(negedge clk);
        checks += 2;
        if (estado !== 2'b10) begin errors++; $display("FAIL single estado_active: got %b expected 10", estado); end
        if (pop !== 4'b0001) begin errors++; $display("FAIL single pop: got %b expected 0001", pop); end
        tick(pop);
        @(negedge clk);
        checks += 4;
        if (push !== 4'b0100) begin errors++; $display("FAIL single push: got %b expected 0100", push); end
        if (data_out_arb !== 12'h2A5) begin errors++; $display("FAIL single data: got %h expected 2a5", data_out_arb); end
        if (cuenta !== 5'd1) begin errors++; $display("FAIL single cuenta: got %0d expected 1", cuenta); end
        if (pop !== 4'b0000) begin errors++; $display("FAIL single pop_after: got %b expected 0000", pop); end
        tick(pop);
        @(negedge clk);
        checks += 3;
        if (estado !== 2'b01) begin errors++; $display("FAIL single back_to_idle: got %b expected 01", estado); end
        if (push !== 4'b0000) begin errors++; $display("FAIL single push_one_cycle: got %b expected 0000", push); end
        if (data_out_arb !== 12'h2A5) begin errors++; $display("FAIL single data_hold: got %h expected 2a5", data_out_arb); end
    endtask

    task automatic test_blocked();
        fifos_almost_full = 4'b0010;
        q[2].push_back(12'h93C);
        drive_inputs();
        @(negedge clk);
        checks += 2;
        if (estado !== 2'b10) begin errors++; $display("FAIL blocked estado_active: got %b expected 10", estado); end
        if (pop !== 4'b0000) begin errors++; $display("FAIL blocked pop_first: got %b expected 0000", pop); end
        tick(pop);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks += 3;
            if (estado !== 2'b11) begin errors++; $display("FAIL blocked estado: got %b expected 11", estado); end
            if (pop !== 4'b0000) begin errors++; $display("FAIL blocked pop: got %b expected 0000", pop); end
            if (push !== 4'b0000) begin errors++; $display("FAIL blocked push: got %b expected 0000", push); end
            if (k == 3) fifos_almost_full = 4'b0000;
            tick(pop);
        end
        @(negedge clk);
        checks++;
        if (pop !== 4'b0100) begin errors++; $display("FAIL blocked pop_release: got %b expected 0100", pop); end
        tick(pop);
        @(negedge clk);
        checks += 3;
        if (push !== 4'b0010) begin errors++; $display("FAIL blocked push_release: got %b expected 0010", push); end
        if (data_out_arb !== 12'h93C) begin errors++; $display("FAIL blocked data: got %h expected 93c", data_out_arb); end
        if (cuenta !== 5'd2) begin errors++; $display("FAIL blocked cuenta: got %0d expected 2", cuenta); end
        tick(pop);
    endtask

    task automatic test_two_classes();
        int np, nq;
        for (int k = 0; k < 3; k++) begin
            q[0].push_back({2'b00, 2'($urandom), 8'($urandom)});
            q[3].push_back({2'b11, 2'($urandom), 8'($urandom)});
        end
        drive_inputs();
        run_traffic("two_classes", 200, 1'b0, np, nq);
        checks += 2;
        if (np !== 6) begin errors++; $display("FAIL two_classes pop_count: got %0d expected 6", np); end
        if (nq !== 6) begin errors++; $display("FAIL two_classes push_count: got %0d expected 6", nq); end
    endtask

    task automatic test_wrap();
        int np, nq;
        int c;
        apply_reset();
        for (int k = 0; k < 33; k++) begin
            c = $urandom_range(3, 0);
            q[c].push_back({2'(c), 10'($urandom)});
        end
        drive_inputs();
        run_traffic("wrap", 400, 1'b0, np, nq);
        checks += 3;
        if (cuenta !== 5'd1) begin errors++; $display("FAIL wrap cuenta: got %0d expected 1", cuenta); end
        if (np !== 33) begin errors++; $display("FAIL wrap pop_count: got %0d expected 33", np); end
        if (nq !== 33) begin errors++; $display("FAIL wrap push_count: got %0d expected 33", nq); end
    endtask

    task automatic test_random_backpressure();
        int np, nq;
        int c;
        for (int k = 0; k < 60; k++) begin
            c = $urandom_range(3, 0);
            q[c].push_back({2'(c), 10'($urandom)});
        end
        drive_inputs();
        run_traffic("random_bp", 3000, 1'b1, np, nq);
        checks += 2;
        if (np !== 60) begin errors++; $display("FAIL random_bp pop_count: got %0d expected 60", np); end
        if (nq !== 60) begin errors++; $display("FAIL random_bp push_count: got %0d expected 60", nq); end
    endtask

    task automatic test_reset_mid();
        int np, nq;
        bit found = 1'b0;
        q[1].push_back(12'h6E7);
        fifos_almost_full = 4'b0000;
        drive_inputs();
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (pop !== 4'b0000) found = 1'b1;
            else tick(pop);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL reset_mid no_pop: got none expected a pop within 10 cycles"); end
        reset = 1'b0;
        #1;
        checks += 4;
        if (pop !== 4'b0000) begin errors++; $display("FAIL reset_mid pop: got %b expected 0000", pop); end
        if (push !== 4'b0000) begin errors++; $display("FAIL reset_mid push: got %b expected 0000", push); end
        if (estado !== 2'b00) begin errors++; $display("FAIL reset_mid estado: got %b expected 00", estado); end
        if (cuenta !== 5'd0) begin errors++; $display("FAIL reset_mid cuenta: got %0d expected 0", cuenta); end
        model_reset();
        tick(4'b0000);
        @(negedge clk);
        checks++;
        if (push !== 4'b0000) begin errors++; $display("FAIL reset_mid push_discarded: got %b expected 0000", push); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (estado !== 2'b01) begin errors++; $display("FAIL reset_mid resume_idle: got %b expected 01", estado); end
        @(negedge clk);
        checks += 2;
        if (estado !== 2'b10) begin errors++; $display("FAIL reset_mid resume_active: got %b expected 10", estado); end
        if (pop !== 4'b0010) begin errors++; $display("FAIL reset_mid resume_pop: got %b expected 0010", pop); end
        tick(pop);
        run_traffic("reset_mid", 50, 1'b0, np, nq);
        checks++;
        if (nq !== 1) begin errors++; $display("FAIL reset_mid push_count: got %0d expected 1", nq); end
    endtask

    initial begin
        reset = 1'b0;
        fifos_almost_full = 4'b0000;
        fifos_empty = 4'b1111;
        data_in_arb = 48'h0;
        model_reset();
        test_reset();
        test_single();
        test_blocked();
        test_two_classes();
        test_wrap();
        test_random_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
